// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC owner, single-outstanding imem req/ack, FIFO-buffered delivery.
// Latency: request issued the edge after FETCH sees space; zero-wait ack delivers two cycles later; full FIFO stalls fetch.

module ifu_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_flush,
   input  logic             i_push_vld,
   input  logic [WIDTH-1:0] i_push_dat,
   input  logic             i_pop_rdy,
   output logic             o_head_vld,
   output logic [WIDTH-1:0] o_head_dat,
   output logic             o_full
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_rd_ptr;
   logic [AW-1:0]    r_wr_ptr;
   logic [AW:0]      r_count;
   logic             w_push;
   logic             w_pop;

   assign w_push = i_push_vld & (r_count != LP_DEPTH);
   assign w_pop  = i_pop_rdy & (r_count != '0);

   // Flush beats any push/pop in the same cycle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head_vld = (r_count != '0);
   assign o_head_dat = r_mem[r_rd_ptr];
   assign o_full     = (r_count == LP_DEPTH);
endmodule

module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_ack,
   input  logic [31:0] i_imem_rdata,
   output logic        o_instr_valid,
   input  logic        i_instr_ready,
   output logic [31:0] o_instruccion,
   output logic [31:0] o_instr_pc,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc
);
   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_WAIT  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   typedef struct packed {
      logic [31:0] word;
      logic [31:0] pc;
   } ifu_entry_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_pc;
   logic [31:0] w_pc_nxt;
   logic [31:0] r_req_addr;
   logic [31:0] w_req_addr_nxt;
   logic [31:0] w_redirect_pc;
   logic        w_full;
   logic        w_push;
   logic        w_pop;
   logic        w_head_vld;
   ifu_entry_t  w_push_dat;
   ifu_entry_t  w_head_dat;

   assign w_redirect_pc = i_redirect_pc & 32'hFFFF_FFFC;
   // Only a live WAIT ack is kept; DRAIN acks and acks while idle are dropped.
   assign w_push     = (r_state == S_WAIT) & i_imem_ack & ~i_redirect;
   assign w_pop      = w_head_vld & i_instr_ready & ~i_redirect;
   assign w_push_dat = '{word: i_imem_rdata, pc: r_req_addr};

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= S_FETCH;
         r_pc       <= RESET_PC;
         r_req_addr <= RESET_PC;
      end else begin
         r_state    <= w_state_nxt;
         r_pc       <= w_pc_nxt;
         r_req_addr <= w_req_addr_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_pc_nxt       = r_pc;
      w_req_addr_nxt = r_req_addr;
      case (r_state)
         S_FETCH: begin
            if (!w_full) begin
               w_state_nxt    = S_WAIT;
               w_req_addr_nxt = r_pc;
            end
         end
         S_WAIT: begin
            if (i_imem_ack) begin
               w_state_nxt = S_FETCH;
               w_pc_nxt    = r_req_addr + 32'd4;
            end
         end
         S_DRAIN: begin
            if (i_imem_ack) begin
               w_state_nxt = S_FETCH;
            end
         end
         default: w_state_nxt = S_FETCH;
      endcase
      // A redirect cancels a not-yet-issued request; an outstanding one must still drain.
      if (i_redirect) begin
         w_pc_nxt       = w_redirect_pc;
         w_req_addr_nxt = r_req_addr;
         w_state_nxt    = ((r_state == S_FETCH) || i_imem_ack) ? S_FETCH : S_DRAIN;
      end
   end

   ifu_fifo #(
      .WIDTH ($bits(ifu_entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_flush    (i_redirect),
      .i_push_vld (w_push),
      .i_push_dat (w_push_dat),
      .i_pop_rdy  (w_pop),
      .o_head_vld (w_head_vld),
      .o_head_dat (w_head_dat),
      .o_full     (w_full)
   );

   assign o_imem_req    = (r_state != S_FETCH);
   assign o_imem_addr   = r_req_addr;
   assign o_instr_valid = w_head_vld;
   assign o_instruccion = w_head_dat.word;
   assign o_instr_pc    = w_head_dat.pc;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: cycle vector table, directed corner sequences, random run vs. stream model.
// Memory model answers with a word derived from the address after a configurable number of wait cycles.

module tb_instr_fetch_unit;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [31:0] instruccion;
   logic [31:0] instr_pc;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;

   instr_fetch_unit dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .o_imem_req    (imem_req),
      .o_imem_addr   (imem_addr),
      .i_imem_ack    (imem_ack),
      .i_imem_rdata  (imem_rdata),
      .o_instr_valid (instr_valid),
      .i_instr_ready (instr_ready),
      .o_instruccion (instruccion),
      .o_instr_pc    (instr_pc),
      .i_redirect    (redirect),
      .i_redirect_pc (redirect_pc)
   );

   initial forever #5 clk = ~clk;

   typedef struct {
      bit          rst;
      bit          rdy;
      bit          rd;
      logic [31:0] rpc;
      int          lat;
      bit          e_req;
      logic [31:0] e_addr;
      bit          e_vld;
      logic [31:0] e_pc;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;
   int   mem_cnt = 0;
   int   cur_lat = 0;
   bit   rand_lat = 0;
   bit   spur = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   function automatic void vr(input int lat);
      vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h0, lat, 1'b0, 32'h0, 1'b0, 32'h0});
   endfunction

   function automatic void vq(input bit rdy, input bit rd, input logic [31:0] rpc,
                              input bit eq, input logic [31:0] ea, input bit ev, input logic [31:0] ep);
      vecs.push_back('{1'b0, rdy, rd, rpc, 0, eq, ea, ev, ep});
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One clock cycle: drive inputs just after the edge, return at the falling edge for sampling.
   task automatic step(input logic rdy, input logic rd, input logic [31:0] rpc);
      @(posedge clk);
      #1;
      instr_ready = rdy;
      redirect    = rd;
      redirect_pc = rpc;
      if (imem_req) begin
         if (mem_cnt == 0 && rand_lat) cur_lat = $urandom_range(0, 3);
         imem_ack   = (mem_cnt >= cur_lat);
         imem_rdata = imem_ack ? mem_word(imem_addr) : $urandom;
         mem_cnt++;
      end else begin
         mem_cnt    = 0;
         imem_ack   = spur && ($urandom_range(0, 9) == 0);
         imem_rdata = $urandom;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n       = 1'b0;
      imem_ack    = 1'b0;
      instr_ready = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      mem_cnt     = 0;
      @(negedge clk);
      chk("reset imem_req", imem_req, 0);
      chk("reset imem_addr", imem_addr, RESET_PC);
      chk("reset instr_valid", instr_valid, 0);
      chk("reset instruccion", instruccion, 0);
      chk("reset instr_pc", instr_pc, 0);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      logic        req_prev, ack_prev, rd_prev;
      logic [31:0] addr_prev, exp_pc;
      int          delivered;
      logic        rdy, rd;
      logic [31:0] rpc;

      // Zero-wait memory, always ready: one word every two cycles.
      vr(0);
      vq(1, 0, 0, 1, 32'h0, 0, 0);
      vq(1, 0, 0, 0, 0, 1, 32'h0);
      vq(1, 0, 0, 1, 32'h4, 0, 0);
      vq(1, 0, 0, 0, 0, 1, 32'h4);
      vq(1, 0, 0, 1, 32'h8, 0, 0);
      vq(1, 0, 0, 0, 0, 1, 32'h8);
      // Consumer stalled for ten cycles: FIFO fills, fetch idles, then drains in order.
      vr(0);
      vq(0, 0, 0, 1, 32'h0, 0, 0);
      vq(0, 0, 0, 0, 0, 1, 32'h0);
      vq(0, 0, 0, 1, 32'h4, 1, 32'h0);
      for (int k = 0; k < 7; k++) vq(0, 0, 0, 0, 0, 1, 32'h0);
      vq(1, 0, 0, 0, 0, 1, 32'h0);
      vq(1, 0, 0, 0, 0, 1, 32'h4);
      vq(1, 0, 0, 1, 32'h8, 0, 0);
      vq(1, 0, 0, 0, 0, 1, 32'h8);
      // Three wait cycles; redirect to 0x100 while the 0x8 request is outstanding.
      vr(3);
      for (int k = 0; k < 4; k++) vq(1, 0, 0, 1, 32'h0, 0, 0);
      vq(1, 0, 0, 0, 0, 1, 32'h0);
      for (int k = 0; k < 4; k++) vq(1, 0, 0, 1, 32'h4, 0, 0);
      vq(1, 0, 0, 0, 0, 1, 32'h4);
      vq(1, 0, 0, 1, 32'h8, 0, 0);
      vq(1, 1, 32'h100, 1, 32'h8, 0, 0);
      vq(1, 0, 0, 1, 32'h8, 0, 0);
      vq(1, 0, 0, 1, 32'h8, 0, 0);
      vq(1, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 4; k++) vq(1, 0, 0, 1, 32'h100, 0, 0);
      vq(1, 0, 0, 0, 0, 1, 32'h100);

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].rst) begin
            cur_lat  = vecs[i].lat;
            rand_lat = 0;
            spur     = 0;
            do_reset();
         end else begin
            step(vecs[i].rdy, vecs[i].rd, vecs[i].rpc);
            chk($sformatf("vec%0d imem_req", i), imem_req, vecs[i].e_req);
            if (vecs[i].e_req) chk($sformatf("vec%0d imem_addr", i), imem_addr, vecs[i].e_addr);
            chk($sformatf("vec%0d instr_valid", i), instr_valid, vecs[i].e_vld);
            if (vecs[i].e_vld) begin
               chk($sformatf("vec%0d instr_pc", i), instr_pc, vecs[i].e_pc);
               chk($sformatf("vec%0d instruccion", i), instruccion, mem_word(vecs[i].e_pc));
            end
         end
      end

      // Redirect coinciding with an ack and a pop: everything in flight is dropped.
      cur_lat = 0;
      do_reset();
      step(0, 0, 0);
      step(0, 0, 0);
      step(1, 1, 32'h203);
      chk("same-cycle pre imem_req", imem_req, 1);
      chk("same-cycle pre instr_valid", instr_valid, 1);
      step(1, 0, 0);
      chk("same-cycle flushed valid", instr_valid, 0);
      chk("same-cycle no req", imem_req, 0);
      step(1, 0, 0);
      chk("same-cycle new imem_addr", imem_addr, 32'h200);
      step(1, 0, 0);
      chk("same-cycle first pc", instr_pc, 32'h200);
      chk("same-cycle first word", instruccion, mem_word(32'h200));

      // Redirect to the top word: the next PC wraps to zero.
      do_reset();
      step(1, 1, 32'hFFFF_FFFC);
      step(1, 0, 0);
      chk("wrap dropped ack", instr_valid, 0);
      step(1, 0, 0);
      chk("wrap imem_addr top", imem_addr, 32'hFFFF_FFFC);
      step(1, 0, 0);
      chk("wrap pc top", instr_pc, 32'hFFFF_FFFC);
      chk("wrap valid top", instr_valid, 1);
      step(1, 0, 0);
      chk("wrap imem_addr zero", imem_addr, 32'h0);
      chk("wrap req zero", imem_req, 1);
      step(1, 0, 0);
      chk("wrap pc zero", instr_pc, 32'h0);
      chk("wrap word zero", instruccion, mem_word(32'h0));

      // Asynchronous reset while a request is outstanding and the FIFO holds data.
      do_reset();
      step(0, 0, 0);
      step(0, 0, 0);
      step(0, 0, 0);
      chk("async pre req", imem_req, 1);
      chk("async pre valid", instr_valid, 1);
      imem_ack = 1'b0;
      rst_n    = 1'b0;
      #1;
      chk("async imem_req", imem_req, 0);
      chk("async instr_valid", instr_valid, 0);
      #2 rst_n = 1'b1;
      mem_cnt = 0;
      step(0, 0, 0);
      chk("async restart req", imem_req, 1);
      chk("async restart addr", imem_addr, RESET_PC);

      // Random run: delivered stream must follow the PC rules of fetch and redirect.
      rand_lat  = 1;
      spur      = 1;
      do_reset();
      exp_pc    = RESET_PC;
      req_prev  = 0;
      ack_prev  = 0;
      rd_prev   = 0;
      addr_prev = '0;
      delivered = 0;
      for (int c = 0; c < 3000; c++) begin
         rdy = ($urandom_range(0, 9) < 7);
         rd  = ($urandom_range(0, 19) == 0);
         rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                           : ($urandom & 32'h0000_0FFF);
         step(rdy, rd, rpc);
         if (req_prev && !ack_prev) begin
            chk($sformatf("rand%0d req held", c), imem_req, 1);
            chk($sformatf("rand%0d addr stable", c), imem_addr, addr_prev);
         end
         if (req_prev && ack_prev) chk($sformatf("rand%0d req gap", c), imem_req, 0);
         if (imem_req) chk($sformatf("rand%0d addr align", c), {30'h0, imem_addr[1:0]}, 0);
         if (rd_prev) chk($sformatf("rand%0d flush valid", c), instr_valid, 0);
         if (instr_valid && rdy && !rd) begin
            chk($sformatf("rand%0d pc", c), instr_pc, exp_pc);
            chk($sformatf("rand%0d word", c), instruccion, mem_word(instr_pc));
            exp_pc = exp_pc + 32'd4;
            delivered++;
         end
         if (rd) exp_pc = rpc & 32'hFFFF_FFFC;
         req_prev  = imem_req;
         ack_prev  = imem_ack;
         addr_prev = imem_addr;
         rd_prev   = rd;
      end
      chk("random deliveries >= 100", 32'(delivered >= 100), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction fetch front end. Owns the PC, issues word reads to instruction memory over a req/ack handshake, and buffers returned words in a small FIFO.
- Delivers `instruccion` plus its PC to the single-cycle datapath over a valid/ready interface.
- Accepts branch/jump redirects from the datapath, flushes buffered words and discards stale in-flight responses.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset (word aligned)
FIFO_DEPTH, 2, instruction buffer entries (power of two, 2..8)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
imem_req  output  1  read request to instruction memory, held until imem_ack
imem_addr  output  32  byte address of request, bits[1:0] always 0, stable while imem_req=1
imem_ack  input  1  one-cycle pulse: imem_rdata valid, request complete (may arrive in the request's own cycle)
imem_rdata  input  32  instruction word returned
instr_valid  output  1  instruccion/instr_pc valid to datapath
instr_ready  input  1  datapath consumes head entry when high with instr_valid
instruccion  output  32  head instruction word
instr_pc  output  32  address of head instruction
redirect  input  1  one-cycle pulse: branch/jump taken
redirect_pc  input  32  new fetch address, bits[1:0] ignored (forced 0)

Behaviour:
- Reset (async assert, sync release):
  - imem_req=0, imem_addr=RESET_PC, instr_valid=0, instruccion=0, instr_pc=0.
  - pc=RESET_PC, FIFO count=0, state=FETCH.
  - Reset mid-transaction abandons any outstanding request; memory shares rst_n.
- Registers:
  - pc: next address to fetch.
  - req_addr: address of the outstanding request, drives imem_addr.
  - FIFO: {word, pc} entries with head/tail pointers and count.
- States:
  - FETCH:
    - When count + 0 < FIFO_DEPTH: assert imem_req with req_addr=pc, go WAIT. Earliest imem_req is the first clk edge after rst_n deasserts.
    - Otherwise idle in FETCH.
  - WAIT:
    - imem_req held high, address stable.
    - On imem_ack without redirect: push {imem_rdata, req_addr}; pc<=req_addr+4; go FETCH (next request issued next cycle if space).
  - DRAIN:
    - imem_req held high with old req_addr until imem_ack.
    - On ack the data is discarded; go FETCH at the redirected pc.
- Zero-wait memory: imem_ack may come in the same cycle imem_req is first asserted. It is treated as the ack of that request.
- Throughput: one request per 2 cycles minimum. Exactly one outstanding request at most.
- Space check: a request is only issued when a FIFO slot is free, so a push never overflows. Push and pop in the same cycle leave count unchanged.
- Output side:
  - instr_valid=(count!=0); instruccion/instr_pc = head entry, registered FIFO storage.
  - Pop when instr_valid & instr_ready.
  - Head holds stable while instr_valid=1 and instr_ready=0.
- Redirect (highest priority, any state):
  - FIFO flushed (count<=0, instr_valid=0 next cycle); any pop or push in that cycle is cancelled.
  - pc<={redirect_pc[31:2],2'b00}.
  - If WAIT with no ack this cycle: go DRAIN.
  - If ack this cycle, or in FETCH: go FETCH, discarding the acked data.
  - Redirect in DRAIN: update pc, stay DRAIN.
- Arithmetic: pc+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.
- imem_ack while imem_req=0 is a protocol error; ignore it (no push).

Test Plan:
- Reset with RESET_PC=0, zero-wait memory returning word=addr, instr_ready=1 → imem_addr sequence 0x0,0x4,0x8; instruccion/instr_pc 0x0,0x4,0x8, one word per 2 cycles.
- instr_ready=0 for 10 cycles → exactly FIFO_DEPTH words buffered, imem_req low afterwards, head stable at pc 0x0. Release ready → 0x0,0x4 drain in order, then fetch resumes at 0x8.
- 3-cycle ack latency; redirect to 0x100 one cycle after a req to 0x8 → imem_addr stays 0x8 until ack, word discarded, next imem_addr=0x100, first delivered instr_pc=0x100.
- Redirect to 0x203 in the same cycle as an ack and a pop → FIFO empty next cycle, acked word dropped, next imem_addr=0x200.
- Redirect to 0xFFFF_FFFC → delivered PCs 0xFFFF_FFFC then 0x0000_0000.
- Assert rst_n=0 while in WAIT → imem_req and instr_valid drop immediately (asynchronously); after release, first imem_addr=RESET_PC.
